// File: rtl/nor_bist_pkg.sv
// rtl/nor_bist_pkg.sv - shared types and helpers for the NOR gate BIST sequencer
// Contents:
//   MAX_N_IN     largest supported NOR input count
//   state_e      sequencer states
//   nor_expected golden NOR response for a vector (upper bits must be zero)
package nor_bist_pkg;

    localparam int MAX_N_IN = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    function automatic logic nor_expected(input logic [MAX_N_IN-1:0] vec);
        return ~(|vec);
    endfunction

endpackage

// File: rtl/nor_bist_ctrl_if.sv
// rtl/nor_bist_ctrl_if.sv - control, status and gate-side signals of the NOR BIST sequencer
// Signals:
//   start       run request from the host
//   dut_in      vector driven to the gate under test
//   dut_out     gate response
//   busy/done   run status, done is a one-cycle pulse
//   pass, err_cnt, first_fail, fail_seen  run results
// Modports:
//   slave  - the sequencer
//   master - host plus gate under test
interface nor_bist_ctrl_if #(
    parameter int N_IN = 2
);

    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_fail;
    logic            fail_seen;

    modport slave (
        input  start,
        input  dut_out,
        output dut_in,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output first_fail,
        output fail_seen
    );

    modport master (
        output start,
        output dut_out,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  first_fail,
        input  fail_seen
    );

endinterface

// File: rtl/nor_bist_timer.sv
// rtl/nor_bist_timer.sv - settle counter holding each vector for SETTLE cycles
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   load      restart the count from zero
//   tick      count one settle cycle
//   expired   high on the tick that completes the SETTLE-th cycle
module nor_bist_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count runs 0..SETTLE-1; the last APPLY cycle is the one where it
    // already sits at SETTLE-1.
    assign expired = tick && (cnt_q == CW'(SETTLE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (tick && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nor_bist_ctrl.sv
// rtl/nor_bist_ctrl.sv - BIST sequencer sweeping all vectors of an external N-input NOR gate
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, aborts a run silently
//   bus  nor_bist_ctrl_if slave: start, dut_in/dut_out, busy, done, pass,
//        err_cnt, first_fail, fail_seen
// Each vector is held SETTLE cycles in APPLY, then the gate output is
// compared against ~|vec in a single CHECK cycle.
module nor_bist_ctrl
    import nor_bist_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    nor_bist_ctrl_if.slave    bus
);

    // One extra bit so the terminal compare never sees a wrapped counter.
    localparam int unsigned LAST_VEC_I = (1 << N_IN) - 1;
    localparam logic [N_IN:0] LAST_VEC = LAST_VEC_I[N_IN:0];

    state_e          state_q, state_d;
    logic [N_IN:0]   vec_q, vec_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;
    logic            fail_seen_q, fail_seen_d;
    logic            pass_q, pass_d;

    logic timer_load;
    logic timer_tick;
    logic timer_expired;
    logic last_vec;
    logic mismatch;

    assign last_vec = (vec_q == LAST_VEC);
    assign mismatch = (bus.dut_out != nor_expected(MAX_N_IN'(vec_q[N_IN-1:0])));

    nor_bist_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start)    state_d = ST_APPLY;
            ST_APPLY:  if (timer_expired) state_d = ST_CHECK;
            ST_CHECK:  state_d = last_vec ? ST_FINISH : ST_APPLY;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; dut_in is forced to 0 outside the sweep
    always_comb begin
        bus.dut_in  = '0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        timer_load  = 1'b0;
        timer_tick  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_load = bus.start;
            end
            ST_APPLY: begin
                bus.dut_in = vec_q[N_IN-1:0];
                bus.busy   = 1'b1;
                timer_tick = 1'b1;
            end
            ST_CHECK: begin
                bus.dut_in = vec_q[N_IN-1:0];
                bus.busy   = 1'b1;
                timer_load = !last_vec;
            end
            ST_FINISH: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Vector counter and result bookkeeping
    always_comb begin
        vec_d        = vec_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        pass_d       = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    vec_d        = '0;
                    err_cnt_d    = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (!fail_seen_q) begin
                        first_fail_d = vec_q[N_IN-1:0];
                        fail_seen_d  = 1'b1;
                    end
                end
                // pass is captured together with the final count so it is
                // already valid in the FINISH (done) cycle.
                if (last_vec) begin
                    pass_d = (err_cnt_d == '0);
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q        <= '0;
            err_cnt_q    <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            vec_q        <= vec_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
            pass_q       <= pass_d;
        end
    end

    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.first_fail = first_fail_q;
    assign bus.fail_seen  = fail_seen_q;

endmodule

// File: doc/nor_bist_ctrl.md
Name: nor_bist_ctrl

Overview:
- Built-in self-test sequencer for an N-input NOR gate.
- Drives the gate inputs through all 2^N_IN vectors on request, samples the gate output after a programmable settle time, and compares it against ~|vector.
- Reports pass/fail, error count and the first failing vector.
- Sits beside the gate library; the gate under test is external, so a bench can inject faults on dut_out.

Parameters:
- N_IN, 2, number of NOR inputs (1..8).
- SETTLE, 1, cycles each vector is held before sampling (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- dut_in  output  N_IN  vector driven to the gate inputs.
- dut_out  input  1  gate output being checked.
- busy  output  1  high from the first APPLY cycle through the last CHECK cycle.
- done  output  1  one-cycle pulse at run end.
- pass  output  1  valid when done: err_cnt==0; held until next accepted start.
- err_cnt  output  N_IN+1  mismatch count for the current/last run.
- first_fail  output  N_IN  index of the first mismatching vector; 0 if none.
- fail_seen  output  1  at least one mismatch in the current/last run.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE.
  - dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_seen=0.
  - vector and wait counters cleared.
  - Applies from any state, including mid-run; the aborted run reports nothing and done does not pulse.
- FSM states: IDLE, APPLY, CHECK, FINISH.
  - IDLE: dut_in=0. When start=1 at edge: clear err_cnt, first_fail, fail_seen and pass; vec=0; wait=0; go to APPLY.
  - APPLY: dut_in=vec; busy=1; wait increments each cycle. After SETTLE cycles in APPLY, go to CHECK.
  - CHECK: dut_in=vec still held; busy=1.
    - expected = ~(|vec).
    - If dut_out != expected: err_cnt+=1; if fail_seen==0, first_fail=vec and fail_seen=1.
    - If vec == 2^N_IN-1, go to FINISH; else vec+=1, wait=0, go to APPLY.
  - FINISH: done=1 for exactly this cycle; busy=0; pass=(err_cnt==0) registered at entry to FINISH; dut_in returns to 0; next state IDLE.
- Timing:
  - Start accepted at edge k gives APPLY(vec 0) in cycle k+1.
  - done is high in cycle k+1+2^N_IN*(SETTLE+1).
  - For N_IN=2, SETTLE=1: done in cycle k+9.
  - IDLE is re-entered in cycle k+10; a new start is accepted no earlier than the edge ending that cycle.
- start is ignored while not in IDLE, including during FINISH; there is no queuing.
- dut_out is sampled only in CHECK; X or glitches during APPLY are don't-care.
- Width/overflow rules:
  - err_cnt max is 2^N_IN, which fits N_IN+1 bits, so no saturation is needed.
  - vec counter is N_IN+1 bits internally so the terminal compare never wraps.
- Results persist in IDLE until the next accepted start or reset.

Decomposition:
- Shared package nor_bist_pkg:
  - state enum (IDLE, APPLY, CHECK, FINISH).
  - function nor_expected(vec) returning ~|vec.
  - MAX_N_IN=8 bound.
- One natural sub-module: nor_bist_timer, the settle/wait counter. It has load and tick inputs and expires after SETTLE cycles.
- The comparator and counters stay in the top level.

Test Plan:
1. Healthy gate (dut_out tied to ~|dut_in), N_IN=2, SETTLE=1, start pulse at cycle 5:
   - dut_in sequence 0,0,1,1,2,2,3,3 from cycle 6.
   - done in cycle 14.
   - pass=1, err_cnt=0, fail_seen=0, first_fail=0.
2. Stuck-at-0 output (dut_out=0):
   - Mismatch only at vec 0.
   - done with pass=0, err_cnt=1, first_fail=0, fail_seen=1.
3. Stuck-at-1 output (dut_out=1):
   - Mismatches at vecs 1,2,3.
   - err_cnt=3, first_fail=1, pass=0.
4. rst asserted during CHECK of vec 2, healthy gate:
   - Next cycle state IDLE, dut_in=0, busy=0, all results 0, no done pulse.
   - A subsequent start completes with pass=1.
5. start held high continuously for 30 cycles:
   - Runs back-to-back; each new start is accepted only in IDLE, one cycle after FINISH.
   - done pulses in cycles k+9 and k+19 (relative to the first acceptance at edge k).
   - Results are cleared at each acceptance.
6. N_IN=3, SETTLE=3, dut_out driven as OR (inverted gate):
   - All 8 vectors mismatch, so err_cnt=8 (4'b1000, no overflow).
   - first_fail=0.
   - done 32 cycles after APPLY(vec 0) begins.
